// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to memory arbiter.
// Holds the line/word typedefs, the arbiter state encoding and a small request helper.
package cache_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  // A D-cache request is pending when either of its strobes is high.
  function automatic logic d_pending(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals seen by the arbiter.
// slave = the arbiter's view, master = the caches plus memory driving it.
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  // Handshake: a cache raises its read/write and holds address/data steady until
  // its one-cycle resp pulse, then drops the request the following cycle.
  // Memory sees mem_read/mem_write held high until its own one-cycle mem_resp;
  // rdata is meaningful only in the cycle its resp is high.
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: picks the next port from IDLE, alternates under contention,
// and decodes the serve/response signals from state and mem_resp.
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_read,
  input  logic       d_read,
  input  logic       d_write,
  input  logic       mem_resp,
  output logic       latch_en,
  output logic       sel_d,
  output logic       serve,
  output logic       i_resp,
  output logic       d_resp,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE    = ARB_IDLE;
  localparam logic [1:0] ST_SERVE_I = ARB_SERVE_I;
  localparam logic [1:0] ST_SERVE_D = ARB_SERVE_D;

  logic [1:0] state_q, state_d;
  logic       last_d_q, last_d_d;   // 1 when the most recent grant went to D
  logic       d_pend;

  assign d_pend = d_pending(d_read, d_write);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    latch_en = 1'b0;
    sel_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // D wins unless I is also waiting and D had the previous grant.
        if (d_pend && (!i_read || !last_d_q)) begin
          latch_en = 1'b1;
          sel_d    = 1'b1;
          last_d_d = 1'b1;
          state_d  = ST_SERVE_D;
        end else if (i_read) begin
          latch_en = 1'b1;
          last_d_d = 1'b0;
          state_d  = ST_SERVE_I;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (mem_resp) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  assign serve  = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);
  assign i_resp = (state_q == ST_SERVE_I) && mem_resp;
  assign d_resp = (state_q == ST_SERVE_D) && mem_resp;
  assign state  = state_q;

endmodule

// File: rtl/cache_arbiter.sv
// Two-port line arbiter between the I-cache, the D-cache and one shared memory port.
// Latches the granted request so requester changes during service are ignored.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  cache_arbiter_if.slave   bus,
  output logic [1:0]       state
);

  logic                  latch_en;
  logic                  sel_d;
  logic                  serve;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  write_q;

  cache_arbiter_control u_control (
    .clk      (clk),
    .reset    (reset),
    .i_read   (bus.i_read),
    .d_read   (bus.d_read),
    .d_write  (bus.d_write),
    .mem_resp (bus.mem_resp),
    .latch_en (latch_en),
    .sel_d    (sel_d),
    .serve    (serve),
    .i_resp   (bus.i_resp),
    .d_resp   (bus.d_resp),
    .state    (state)
  );

  // A write wins over a simultaneous read, so the op latch only records d_write.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (latch_en) begin
      addr_q  <= sel_d ? bus.d_address : bus.i_address;
      wdata_q <= sel_d ? bus.d_wdata : '0;
      write_q <= sel_d & bus.d_write;
    end
  end

  assign bus.mem_read    = serve & ~write_q;
  assign bus.mem_write   = serve &  write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, hand sequences for
// contention/reset/stale-response corners, and randomized rounds against a grant-order model.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  localparam int AW    = 16;
  localparam int LW    = 128;
  localparam int EXP_W = 2 + AW + LW;   // {is_d, write, addr, wdata}

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic model_last_d;

  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
    logic          exp_read;
    logic          exp_write;
  } vec_t;

  vec_t vt[6];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0b required %0b", name, act, exp);
    end
  endtask

  function automatic vec_t mk_vec(input logic is_d, input logic rd, input logic wr,
                                  input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                                  input logic [LW-1:0] rdata, input int lat,
                                  input logic er, input logic ew);
    vec_t v;
    v.is_d = is_d; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.lat = lat; v.exp_read = er; v.exp_write = ew;
    return v;
  endfunction

  function automatic logic [EXP_W-1:0] mk_exp(input logic is_d, input logic wr,
                                              input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    return {is_d, wr, addr, wdata};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_last_d = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    if (v.is_d) begin
      bus.d_read = v.rd; bus.d_write = v.wr; bus.d_address = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_read = 1'b1; bus.i_address = v.addr;
    end
    if (v.rd && v.wr) $display("note: vector %0d drives d_read and d_write together (illegal)", idx);
    @(negedge clk);
    check1($sformatf("v%0d strobe in request cycle", idx), bus.mem_read | bus.mem_write, 1'b0);
    for (int k = 1; k <= v.lat; k++) begin
      @(posedge clk); #1;
      if (k == v.lat) begin bus.mem_resp = 1'b1; bus.mem_rdata = v.rdata; end
      @(negedge clk);
      check1($sformatf("v%0d c%0d mem_read", idx, k), bus.mem_read, v.exp_read);
      check1($sformatf("v%0d c%0d mem_write", idx, k), bus.mem_write, v.exp_write);
      check($sformatf("v%0d c%0d mem_address", idx, k), LW'(bus.mem_address), LW'(v.addr));
      if (v.exp_write) check($sformatf("v%0d c%0d mem_wdata", idx, k), bus.mem_wdata, v.wdata);
      check1($sformatf("v%0d c%0d own resp", idx, k), v.is_d ? bus.d_resp : bus.i_resp, k == v.lat);
      check1($sformatf("v%0d c%0d other resp", idx, k), v.is_d ? bus.i_resp : bus.d_resp, 1'b0);
      if (k == v.lat)
        check($sformatf("v%0d rdata", idx), v.is_d ? bus.d_rdata : bus.i_rdata, v.rdata);
    end
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    @(negedge clk);
    check1($sformatf("v%0d strobes after resp", idx), bus.mem_read | bus.mem_write, 1'b0);
    check1($sformatf("v%0d resp after resp", idx), bus.i_resp | bus.d_resp, 1'b0);
    model_last_d = v.is_d;
  endtask

  // Plays memory and both caches while requests are outstanding; every grant the
  // DUT issues is matched against the head of exp_q.
  task automatic run_engine(input int budget);
    logic [EXP_W-1:0] cur;
    logic             active, after_resp, resp_now, drop_i, drop_d;
    int               wait_n, cyc;
    logic [LW-1:0]    rd_val;
    cur = '0; active = 0; after_resp = 0; resp_now = 0; drop_i = 0; drop_d = 0;
    wait_n = 0; cyc = 0; rd_val = '0;
    while ((bus.i_read || bus.d_read || bus.d_write) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      bus.mem_resp = resp_now;
      if (resp_now) bus.mem_rdata = rd_val;
      if (drop_i) bus.i_read = 1'b0;
      if (drop_d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      drop_i = 0; drop_d = 0;
      @(negedge clk);
      if (bus.mem_resp) begin
        check1("eng strobe in resp cycle", bus.mem_read | bus.mem_write, 1'b1);
        check1("eng owner resp", cur[EXP_W-1] ? bus.d_resp : bus.i_resp, 1'b1);
        check1("eng other resp", cur[EXP_W-1] ? bus.i_resp : bus.d_resp, 1'b0);
        check("eng rdata", cur[EXP_W-1] ? bus.d_rdata : bus.i_rdata, rd_val);
        if (cur[EXP_W-1]) drop_d = 1; else drop_i = 1;
        resp_now = 0; active = 0; after_resp = 1;
      end else if (after_resp) begin
        check1("eng turnaround idle", bus.mem_read | bus.mem_write, 1'b0);
        check1("eng no resp in turnaround", bus.i_resp | bus.d_resp, 1'b0);
        after_resp = 0;
      end else if (!active) begin
        check1("eng grant issued", bus.mem_read | bus.mem_write, 1'b1);
        if (bus.mem_read | bus.mem_write) begin
          if (exp_q.size() == 0) begin
            check1("eng unexpected grant", 1'b1, 1'b0);
          end else begin
            cur = exp_q.pop_front();
            active = 1;
            check1("eng grant port write", bus.mem_write, cur[EXP_W-2]);
            check1("eng grant port read", bus.mem_read, !cur[EXP_W-2]);
            check("eng grant address", LW'(bus.mem_address), LW'(cur[LW +: AW]));
            wait_n = $urandom_range(0, 3);
            rd_val = {$urandom, $urandom, $urandom, $urandom};
            if (wait_n == 0) resp_now = 1;
          end
        end
      end else begin
        check1("eng hold write", bus.mem_write, cur[EXP_W-2]);
        check1("eng hold read", bus.mem_read, !cur[EXP_W-2]);
        check("eng hold address", LW'(bus.mem_address), LW'(cur[LW +: AW]));
        if (cur[EXP_W-2]) check("eng hold wdata", bus.mem_wdata, cur[LW-1:0]);
        check1("eng no early resp", bus.i_resp | bus.d_resp, 1'b0);
        wait_n--;
        if (wait_n <= 0) resp_now = 1;
      end
    end
    if (cyc >= budget) begin
      vectors++; miscompares++;
      $display("FAIL engine timeout: actual %0d cycles required under %0d", cyc, budget);
      exp_q.delete();
      do_reset();
    end
    check("grants outstanding", LW'(exp_q.size()), '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [AW-1:0] ai, ad;
    logic [LW-1:0] wd;
    logic          w;
    int            mask;

    reset = 1'b1;
    idle_inputs();
    do_reset();

    @(negedge clk);
    check1("reset mem_read", bus.mem_read, 1'b0);
    check1("reset mem_write", bus.mem_write, 1'b0);
    check1("reset i_resp", bus.i_resp, 1'b0);
    check1("reset d_resp", bus.d_resp, 1'b0);
    check("reset mem_address", LW'(bus.mem_address), '0);
    check("reset mem_wdata", bus.mem_wdata, '0);
    check("reset state", LW'(state), LW'(ARB_IDLE));

    vt[0] = mk_vec(0, 1, 0, 16'h1230, '0, {16{8'hA5}}, 5, 1, 0);
    vt[1] = mk_vec(1, 0, 1, 16'h4440, {4{32'hDEADBEEF}}, '0, 3, 0, 1);
    vt[2] = mk_vec(1, 1, 0, 16'h2000, '0, {4{32'h01234567}}, 1, 1, 0);
    vt[3] = mk_vec(1, 1, 1, 16'h6660, {8{16'hC3C3}}, '0, 2, 0, 1);
    vt[4] = mk_vec(0, 1, 0, 16'hFFF0, '0, {LW{1'b1}}, 1, 1, 0);
    vt[5] = mk_vec(1, 0, 1, 16'h0000, {LW{1'b1}}, '0, 4, 0, 1);
    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // D changes its address while being served; the latched one must stay on the bus.
    @(posedge clk); #1;
    bus.d_read = 1'b1; bus.d_address = 16'h4440;
    @(posedge clk); #1;
    bus.d_address = 16'h8880; bus.d_wdata = {4{32'h5555AAAA}};
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 3) bus.mem_resp = 1'b1;
      @(negedge clk);
      check($sformatf("addr change c%0d mem_address", k), LW'(bus.mem_address), LW'(16'h4440));
      check1($sformatf("addr change c%0d mem_read", k), bus.mem_read, 1'b1);
      check1($sformatf("addr change c%0d d_resp", k), bus.d_resp, k == 3);
    end
    @(posedge clk); #1;
    bus.mem_resp = 1'b0; bus.d_read = 1'b0;
    @(negedge clk);
    check1("addr change strobe drop", bus.mem_read, 1'b0);
    model_last_d = 1'b1;

    // mem_resp held for two cycles yields a single i_resp.
    @(posedge clk); #1;
    bus.i_read = 1'b1; bus.i_address = 16'h7770;
    @(posedge clk); #1;
    bus.mem_resp = 1'b1; bus.mem_rdata = {4{32'hCAFEF00D}};
    @(negedge clk);
    check1("long resp first i_resp", bus.i_resp, 1'b1);
    @(posedge clk); #1;
    bus.i_read = 1'b0;
    @(negedge clk);
    check1("long resp second i_resp", bus.i_resp, 1'b0);
    check1("long resp strobe", bus.mem_read, 1'b0);
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;

    // Reset during SERVE_I, then a stale mem_resp.
    @(posedge clk); #1;
    bus.i_read = 1'b1; bus.i_address = 16'h1230;
    @(posedge clk); #1;
    @(negedge clk);
    check1("midreset serving", bus.mem_read, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.i_read = 1'b0; bus.mem_resp = 1'b1;
    @(negedge clk);
    check1("midreset mem_read", bus.mem_read, 1'b0);
    check1("midreset mem_write", bus.mem_write, 1'b0);
    check1("midreset stale i_resp", bus.i_resp, 1'b0);
    check("midreset state", LW'(state), LW'(ARB_IDLE));
    check("midreset address latch", LW'(bus.mem_address), '0);
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
    @(negedge clk);
    check1("midreset later i_resp", bus.i_resp, 1'b0);
    model_last_d = 1'b0;

    // Contention from reset: expect D, I, D, I.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      bus.i_read = 1'b1; bus.i_address = 16'h1000 + 16'(r * 16);
      bus.d_read = 1'b1; bus.d_address = 16'h2000 + 16'(r * 16);
      exp_q.push_back(mk_exp(1'b1, 1'b0, 16'h2000 + 16'(r * 16), '0));
      exp_q.push_back(mk_exp(1'b0, 1'b0, 16'h1000 + 16'(r * 16), '0));
      run_engine(60);
    end
    model_last_d = 1'b0;

    // Randomized rounds; the model only knows "alternate under contention".
    for (int r = 0; r < 40; r++) begin
      mask = $urandom_range(1, 3);
      ai = {12'($urandom_range(0, 4095)), 4'h0};
      ad = {12'($urandom_range(0, 4095)), 4'h0};
      wd = {$urandom, $urandom, $urandom, $urandom};
      w  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (mask[0]) begin bus.i_read = 1'b1; bus.i_address = ai; end
      if (mask[1]) begin
        bus.d_read = !w; bus.d_write = w; bus.d_address = ad; bus.d_wdata = wd;
      end
      if (mask == 3 && !model_last_d) begin
        exp_q.push_back(mk_exp(1'b1, w, ad, wd));
        exp_q.push_back(mk_exp(1'b0, 1'b0, ai, '0));
        model_last_d = 1'b0;
      end else if (mask == 3) begin
        exp_q.push_back(mk_exp(1'b0, 1'b0, ai, '0));
        exp_q.push_back(mk_exp(1'b1, w, ad, wd));
        model_last_d = 1'b1;
      end else if (mask == 1) begin
        exp_q.push_back(mk_exp(1'b0, 1'b0, ai, '0));
        model_last_d = 1'b0;
      end else begin
        exp_q.push_back(mk_exp(1'b1, w, ad, wd));
        model_last_d = 1'b1;
      end
      run_engine(60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
